// File: rtl/rl_ram_arb_pkg.sv
// Shared helpers for the 1R1W RAM arbiter: packed-slice extraction and
// one-hot to binary conversion used to derive the winning requester index.
package rl_ram_arb_pkg;

    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;
    localparam int VEC_W   = 2048;
    localparam int SLICE_W = 64;

    // Callers zero-extend their packed bus to VEC_W and truncate the result.
    function automatic logic [SLICE_W-1:0] get_slice(
        input logic [VEC_W-1:0] vec,
        input int               idx,
        input int               w
    );
        logic [VEC_W-1:0]   v_sh;
        logic [SLICE_W-1:0] v_res;
        v_sh  = vec >> (idx * w);
        v_res = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            if (i < w) begin
                v_res[i] = v_sh[i];
            end
        end
        return v_res;
    endfunction

    function automatic logic [IDX_W-1:0] onehot2bin(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] v_bin;
        v_bin = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                v_bin = v_bin | IDX_W'(i);
            end
        end
        return v_bin;
    endfunction

endpackage

// File: rtl/rl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the priority pointer wins;
// the pointer moves past the winner only when en is set.
module rl_rr_arbiter
    import rl_ram_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] r_ptr;

    always_comb begin
        logic v_found;
        int   v_k;
        gnt     = '0;
        v_found = 1'b0;
        v_k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            v_k = int'(r_ptr) + i;
            if (v_k >= NREQ) begin
                v_k = v_k - NREQ;
            end
            if (!v_found && req[v_k]) begin
                gnt[v_k] = 1'b1;
                v_found  = 1'b1;
            end
        end
    end

    assign idx = IW'(onehot2bin(MAX_REQ'(gnt)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (en && (|req)) begin
            r_ptr <= (int'(idx) == NREQ - 1) ? '0 : IW'(int'(idx) + 1);
        end
    end

endmodule

// File: rtl/rl_ram_1r1w_arb.sv
// Shares one 1R1W RAM between NREQ writers and NREQ readers with independent
// round-robin arbiters; reads colliding with a same-address write are stalled.
module rl_ram_1r1w_arb
    import rl_ram_arb_pkg::*;
#(
    parameter  int ABITS  = 10,
    parameter  int DBITS  = 32,
    parameter  int NREQ   = 4,
    localparam int BEBITS = (DBITS + 7) / 8,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         wreq_i,
    input  logic [NREQ*ABITS-1:0]   waddr_i,
    input  logic [NREQ*DBITS-1:0]   wdata_i,
    input  logic [NREQ*BEBITS-1:0]  wbe_i,
    output logic [NREQ-1:0]         wgnt_o,
    input  logic [NREQ-1:0]         rreq_i,
    input  logic [NREQ*ABITS-1:0]   raddr_i,
    output logic [NREQ-1:0]         rgnt_o,
    output logic [NREQ-1:0]         rvalid_o,
    output logic [DBITS-1:0]        rdata_o,
    output logic [ABITS-1:0]        ram_waddr_o,
    output logic [DBITS-1:0]        ram_din_o,
    output logic [BEBITS-1:0]       ram_be_o,
    output logic                    ram_we_o,
    output logic [ABITS-1:0]        ram_raddr_o,
    input  logic [DBITS-1:0]        ram_dout_i
);

    logic [ABITS-1:0]  w_waddr [NREQ];
    logic [DBITS-1:0]  w_wdata [NREQ];
    logic [BEBITS-1:0] w_wbe   [NREQ];
    logic [ABITS-1:0]  w_raddr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_waddr[gi] = ABITS'(get_slice(VEC_W'(waddr_i), gi, ABITS));
            assign w_wdata[gi] = DBITS'(get_slice(VEC_W'(wdata_i), gi, DBITS));
            assign w_wbe[gi]   = BEBITS'(get_slice(VEC_W'(wbe_i), gi, BEBITS));
            assign w_raddr[gi] = ABITS'(get_slice(VEC_W'(raddr_i), gi, ABITS));
        end
    endgenerate

    logic [NREQ-1:0]  w_wgnt;
    logic [IW-1:0]    w_widx;
    logic             w_wany;
    logic [NREQ-1:0]  w_rcand;
    logic [IW-1:0]    w_ridx;
    logic             w_rany;
    logic [ABITS-1:0] w_rcand_addr;
    logic             w_hazard;
    logic [NREQ-1:0]  r_rgnt_q;

    rl_rr_arbiter #(.NREQ(NREQ)) u_warb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   (wreq_i),
        .en    (1'b1),
        .gnt   (w_wgnt),
        .idx   (w_widx)
    );

    // The read pointer is frozen on a hazard so the same candidate retries.
    rl_rr_arbiter #(.NREQ(NREQ)) u_rarb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   (rreq_i),
        .en    (!w_hazard),
        .gnt   (w_rcand),
        .idx   (w_ridx)
    );

    assign w_wany      = |wreq_i;
    assign wgnt_o      = w_wgnt;
    assign ram_we_o    = w_wany;
    assign ram_waddr_o = w_wany ? w_waddr[w_widx] : '0;
    assign ram_din_o   = w_wany ? w_wdata[w_widx] : '0;
    assign ram_be_o    = w_wany ? w_wbe[w_widx]   : '0;

    assign w_rany       = |rreq_i;
    assign w_rcand_addr = w_raddr[w_ridx];
    assign w_hazard     = ram_we_o && w_rany && (w_rcand_addr == ram_waddr_o);
    assign rgnt_o       = w_hazard ? '0 : w_rcand;
    assign ram_raddr_o  = w_rany ? w_rcand_addr : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rgnt_q <= '0;
        end else begin
            r_rgnt_q <= rgnt_o;
        end
    end

    assign rvalid_o = r_rgnt_q;
    assign rdata_o  = ram_dout_i;

endmodule

// File: tb/tb_rl_ram_1r1w_arb.sv
// Directed bench for rl_ram_1r1w_arb with a RAM model, a per-cycle reference
// model of the arbitration rules, and literal expectations for key scenarios.
module tb_rl_ram_1r1w_arb;

    localparam int ABITS  = 10;
    localparam int DBITS  = 32;
    localparam int NREQ   = 4;
    localparam int BEBITS = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        wreq;
    logic [NREQ*ABITS-1:0]  waddr;
    logic [NREQ*DBITS-1:0]  wdata;
    logic [NREQ*BEBITS-1:0] wbe;
    logic [NREQ-1:0]        wgnt;
    logic [NREQ-1:0]        rreq;
    logic [NREQ*ABITS-1:0]  raddr;
    logic [NREQ-1:0]        rgnt;
    logic [NREQ-1:0]        rvalid;
    logic [DBITS-1:0]       rdata;
    logic [ABITS-1:0]       ram_waddr;
    logic [DBITS-1:0]       ram_din;
    logic [BEBITS-1:0]      ram_be;
    logic                   ram_we;
    logic [ABITS-1:0]       ram_raddr;
    logic [DBITS-1:0]       ram_dout;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    rl_ram_1r1w_arb #(.ABITS(ABITS), .DBITS(DBITS), .NREQ(NREQ)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wreq_i      (wreq),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .wbe_i       (wbe),
        .wgnt_o      (wgnt),
        .rreq_i      (rreq),
        .raddr_i     (raddr),
        .rgnt_o      (rgnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .ram_waddr_o (ram_waddr),
        .ram_din_o   (ram_din),
        .ram_be_o    (ram_be),
        .ram_we_o    (ram_we),
        .ram_raddr_o (ram_raddr),
        .ram_dout_i  (ram_dout)
    );

    // Vendor RAM stand-in: registered read address, unregistered output.
    logic [DBITS-1:0] ram_mem [1 << ABITS];
    logic [ABITS-1:0] ram_raddr_q;
    logic             ram_clear;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < (1 << ABITS); i++) ram_mem[i] <= '0;
        end else if (ram_we) begin
            for (int b = 0; b < BEBITS; b++)
                if (ram_be[b]) ram_mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        ram_raddr_q <= ram_raddr;
    end
    assign ram_dout = ram_mem[ram_raddr_q];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: arbitration from modular search, memory as a plain array.
    initial begin
        logic [DBITS-1:0] gold [1 << ABITS];
        int               mw, mr, wk, rk, k;
        logic [NREQ-1:0]  ew, er, pend;
        logic [DBITS-1:0] pend_data;
        logic [DBITS-1:0] wd;
        logic [BEBITS-1:0] wb;
        logic [ABITS-1:0] wa;
        bit               haz;
        for (int i = 0; i < (1 << ABITS); i++) gold[i] = '0;
        mw = 0; mr = 0; pend = '0; pend_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mw = 0; mr = 0; pend = '0;
            end
            chk("m_rvalid", 32'(rvalid), 32'(pend));
            if (pend != '0) chk("m_rdata", rdata, pend_data);

            wk = -1;
            for (int i = 0; i < NREQ; i++) begin
                k = (mw + i) % NREQ;
                if (wk < 0 && wreq[k]) wk = k;
            end
            ew = '0;
            if (wk >= 0) ew[wk] = 1'b1;
            chk("m_wgnt", 32'(wgnt), 32'(ew));
            chk("m_we", 32'(ram_we), (wk >= 0) ? 32'd1 : 32'd0);
            wa = '0; wd = '0; wb = '0;
            if (wk >= 0) begin
                wa = waddr[wk*ABITS +: ABITS];
                wd = wdata[wk*DBITS +: DBITS];
                wb = wbe[wk*BEBITS +: BEBITS];
                chk("m_waddr", 32'(ram_waddr), 32'(wa));
                chk("m_din", ram_din, wd);
                chk("m_be", 32'(ram_be), 32'(wb));
            end

            rk = -1;
            for (int i = 0; i < NREQ; i++) begin
                k = (mr + i) % NREQ;
                if (rk < 0 && rreq[k]) rk = k;
            end
            haz = (wk >= 0) && (rk >= 0) && (raddr[rk*ABITS +: ABITS] == wa);
            er = '0;
            if (rk >= 0 && !haz) er[rk] = 1'b1;
            chk("m_rgnt", 32'(rgnt), 32'(er));
            if (er != '0) begin
                chk("m_raddr", 32'(ram_raddr), 32'(raddr[rk*ABITS +: ABITS]));
                pend_data = gold[raddr[rk*ABITS +: ABITS]];
            end

            if (rst) begin
                pend = '0;
            end else begin
                if (wk >= 0) mw = (wk + 1) % NREQ;
                if (er != '0) mr = (rk + 1) % NREQ;
                pend = er;
            end
            if (wk >= 0 && !ram_clear)
                for (int b = 0; b < BEBITS; b++)
                    if (wb[b]) gold[wa][8*b +: 8] = wd[8*b +: 8];
        end
    end

    task automatic clr_all();
        wreq = '0; waddr = '0; wdata = '0; wbe = '0;
        rreq = '0; raddr = '0;
    endtask

    task automatic set_w(input int k, input logic [ABITS-1:0] a,
                         input logic [DBITS-1:0] d, input logic [BEBITS-1:0] be);
        wreq[k] = 1'b1;
        waddr[k*ABITS +: ABITS]   = a;
        wdata[k*DBITS +: DBITS]   = d;
        wbe[k*BEBITS +: BEBITS]   = be;
    endtask

    task automatic set_r(input int k, input logic [ABITS-1:0] a);
        rreq[k] = 1'b1;
        raddr[k*ABITS +: ABITS] = a;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ram_clear = 1'b1;
        clr_all();
        repeat (2) @(posedge clk);
        #1;
        ram_clear = 1'b0;
        @(negedge clk);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_wgnt", 32'(wgnt), 32'd0);
        chk("reset_rgnt", 32'(rgnt), 32'd0);
        chk("reset_we", 32'(ram_we), 32'd0);
        next();
        rst = 1'b0;

        // single write then read
        set_w(2, 10'h005, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        chk("t1_wgnt", 32'(wgnt), 32'b0100);
        next(); clr_all(); set_r(1, 10'h005);
        @(negedge clk);
        chk("t1_rgnt", 32'(rgnt), 32'b0010);
        next(); clr_all();
        @(negedge clk);
        chk("t1_rvalid", 32'(rvalid), 32'b0010);
        chk("t1_rdata", rdata, 32'hDEADBEEF);

        // round-robin from reset
        next(); rst = 1'b1;
        next(); rst = 1'b0;
        for (int k = 0; k < NREQ; k++) set_w(k, 10'(32'h20 + k), 32'h1000_0000 + k, 4'hF);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t2_rr_wgnt", 32'(wgnt), 32'(1 << (c % NREQ)));
            next();
        end
        clr_all();

        // same-address hazard
        set_w(0, 10'h010, 32'hA5A51234, 4'hF); set_r(3, 10'h010);
        @(negedge clk);
        chk("t3_haz_rgnt", 32'(rgnt), 32'd0);
        chk("t3_haz_wgnt", 32'(wgnt), 32'b0001);
        next(); clr_all(); set_r(3, 10'h010);
        @(negedge clk);
        chk("t3_retry_rgnt", 32'(rgnt), 32'b1000);
        next(); clr_all();
        @(negedge clk);
        chk("t3_rvalid", 32'(rvalid), 32'b1000);
        chk("t3_rdata", rdata, 32'hA5A51234);

        // different addresses: both granted
        next(); set_w(0, 10'h010, 32'h11112222, 4'hF); set_r(2, 10'h011);
        @(negedge clk);
        chk("t4_wgnt", 32'(wgnt), 32'b0001);
        chk("t4_rgnt", 32'(rgnt), 32'b0100);
        next(); clr_all();
        @(negedge clk);
        chk("t4_rvalid", 32'(rvalid), 32'b0100);
        chk("t4_rdata", rdata, 32'h0000_0000);

        // byte enables
        next(); set_w(1, 10'h030, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        chk("t5_wgnt_a", 32'(wgnt), 32'b0010);
        next(); clr_all(); set_w(1, 10'h030, 32'h00000000, 4'b0101);
        @(negedge clk);
        chk("t5_wgnt_b", 32'(wgnt), 32'b0010);
        next(); clr_all(); set_r(0, 10'h030);
        @(negedge clk);
        chk("t5_rgnt", 32'(rgnt), 32'b0001);
        next(); clr_all();
        @(negedge clk);
        chk("t5_rvalid", 32'(rvalid), 32'b0001);
        chk("t5_rdata", rdata, 32'hFF00FF00);

        // reset while a read is in flight
        next(); set_r(2, 10'h030);
        @(negedge clk);
        chk("t6_rgnt", 32'(rgnt), 32'b0100);
        next(); clr_all(); rst = 1'b1;
        @(negedge clk);
        chk("t6_rvalid_dropped", 32'(rvalid), 32'd0);
        next();
        next(); rst = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            set_w(k, 10'(32'h40 + k), 32'h2000_0000 + k, 4'hF);
            set_r(k, 10'(32'h50 + k));
        end
        @(negedge clk);
        chk("t6_wgnt_first", 32'(wgnt), 32'b0001);
        chk("t6_rgnt_first", 32'(rgnt), 32'b0001);
        next();
        @(negedge clk);
        chk("t6_rvalid_b2b", 32'(rvalid), 32'b0001);
        chk("t6_rgnt_second", 32'(rgnt), 32'b0010);
        next();
        @(negedge clk);
        chk("t6_rvalid_b2b2", 32'(rvalid), 32'b0010);
        next(); next();
        clr_all();
        repeat (3) next();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/rl_ram_1r1w_arb.md
# rl_ram_1r1w_arb

Multi-requester arbiter that shares one 1R1W RAM instance between NREQ write clients and NREQ read clients. Write and read ports are arbitrated independently, each with a round-robin arbiter. The block steers the winning request onto the RAM ports and returns read data with a per-requester valid strobe. It also stalls reads that would collide with a same-cycle write to the same address, because mixed-port read-during-write output is undefined. It sits between client logic and the vendor RAM wrapper, which has a registered read address and an unregistered read output.

## Interface
- ABITS, 10, RAM address width
- DBITS, 32, RAM data width; BEBITS = (DBITS+7)/8
- NREQ, 4, number of write requesters and number of read requesters (2..16)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- wreq_i  in  NREQ  write request per client; held until granted
- waddr_i  in  NREQ*ABITS  write addresses, client k at [k*ABITS +: ABITS]
- wdata_i  in  NREQ*DBITS  write data, packed likewise
- wbe_i  in  NREQ*BEBITS  byte enables, packed likewise
- wgnt_o  out  NREQ  one-hot write grant; the write is committed on this edge
- rreq_i  in  NREQ  read request per client; held until granted
- raddr_i  in  NREQ*ABITS  read addresses, packed
- rgnt_o  out  NREQ  one-hot read grant
- rvalid_o  out  NREQ  one-hot; rdata_o is valid for that client
- rdata_o  out  DBITS  shared read data
- ram_waddr_o  out  ABITS, ram_din_o  out  DBITS, ram_be_o  out  BEBITS, ram_we_o  out  1  RAM write port
- ram_raddr_o  out  ABITS  RAM read address
- ram_dout_i  in  DBITS  RAM read data, valid the cycle after its address is presented

## Operation
- Each arbiter keeps a priority pointer, wptr or rptr, of width $clog2(NREQ). Both reset to 0.
- **Write arbiter**
  - The winner is the first requesting index at or after wptr, searching modulo NREQ.
  - wgnt_o, ram_we_o, ram_waddr_o, ram_din_o and ram_be_o are driven combinationally from the winner.
  - When no client requests, ram_we_o = 0 and the data/address outputs are don't-care (drive 0).
  - After a grant, wptr takes winner+1, wrapping to 0 after NREQ-1.
- **Read arbiter**
  - The candidate is chosen by the same round-robin rule from rptr.
  - **Hazard check:** if ram_we_o = 1 and the candidate address equals ram_waddr_o, the read is not granted that cycle.
    - rgnt_o stays all zero.
    - rptr holds its value.
    - The same candidate is retried next cycle.
  - Otherwise rgnt_o is one-hot for the candidate and ram_raddr_o is the candidate address.
  - After a grant, rptr takes candidate+1 with the same wrap rule.
- **Return path**
  - A registered copy of rgnt_o (rgnt_q) drives rvalid_o.
  - rdata_o = ram_dout_i passes through without a register.
- **Independence**
  - Write and read arbitration never block each other, except through the hazard rule.
  - One write and one read can be granted in the same cycle.
- **Reset**
  - Reset in mid-operation clears rgnt_q and both pointers. An in-flight read is dropped and its rvalid is never issued.
  - Clients must re-request after reset.

## Timing
- Grant latency is 0 cycles: a request seen in cycle n is granted in cycle n if it wins.
- Read data latency is 1 cycle: rvalid_o[k] = 1 in cycle n+1 for rgnt_o[k] in cycle n.
- Back-to-back reads are allowed, one per cycle, with no bubble.
- Fairness: a continuously asserted request is granted within NREQ cycles. A read request can additionally be delayed by consecutive same-address write hazards.
- Reset values:
  - rvalid_o = 0.
  - With no requests present: wgnt_o = 0, rgnt_o = 0, ram_we_o = 0.
- Critical path: round-robin search → address compare → rgnt_o. NREQ ≤ 16 keeps this within a single cycle.

## Structure
- Package rl_ram_arb_pkg holds:
  - the function that unpacks a packed vector slice by index;
  - the one-hot to binary function used to derive the winner index.
- Sub-module rl_rr_arbiter #(NREQ) takes req, en, clk_i and rst_i, and produces a one-hot gnt and a binary idx. It owns its pointer, which advances only when en is set and a grant is issued.
  - Write arbiter instance: en = 1.
  - Read arbiter instance: en = !hazard.
- The top level contains the muxes, the address comparator and the rgnt_q register.

## Test plan
- **Single write, then read:** client 2 writes 0xDEADBEEF to address 0x05 with wbe_i = 4'hF, then client 1 reads 0x05 → wgnt_o = 4'b0100 in that cycle; one cycle after the read grant, rvalid_o = 4'b0010 and rdata_o = 0xDEADBEEF.
- **Round-robin:** all four write requests held for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3.
- **Hazard:** client 0 writes 0x10 while client 3 reads 0x10 in the same cycle → rgnt_o = 0 in that cycle; client 3 is granted the next cycle and returns the newly written data.
- **No hazard:** a write to 0x10 concurrent with a read of 0x11 → both granted in the same cycle.
- **Byte enables:** write 0xFFFFFFFF, then write 0x00000000 with wbe_i = 4'b0101, then read → 0xFF00FF00.
- **Reset mid-read:** rst_i asserted in the cycle after a read grant → rvalid_o = 0 for that read; both pointers return to 0, so the first grant after release goes to client 0 when all clients request.
